// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared FSM state encoding, default widths and the wait-counter width helper.
// Imported by mem_access_ctrl_if, mem_wait_counter and mem_access_ctrl.
package mem_ctrl_pkg;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_ADDRESS_WIDTH  = 9;
  localparam int DEF_CPU_ADDR_WIDTH = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_e;
  // Width of a down-counter that must hold WAIT_CYCLES; never narrower than one bit.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: control-unit request/response bus plus RAM strobe bus.
// Signals: req/we/addr/wdata (request), ready/done/rdata/err (response),
//          ram_read/ram_write/ram_address/ram_data_in/ram_data_out (RAM side).
// Modports: master = control unit, slave = mem_access_ctrl, ram = word-addressed RAM.
interface mem_access_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int CPU_ADDR_WIDTH = DEF_CPU_ADDR_WIDTH
);
  logic                      req;
  logic                      we;
  logic [CPU_ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]     wdata;
  logic                      ready;
  logic                      done;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      err;
  logic                      ram_read;
  logic                      ram_write;
  logic [ADDRESS_WIDTH-1:0]  ram_address;
  logic [DATA_WIDTH-1:0]     ram_data_in;
  logic [DATA_WIDTH-1:0]     ram_data_out;
  modport master (output req, we, addr, wdata, input ready, done, rdata, err);
  modport slave (
    input  req, we, addr, wdata, ram_data_out,
    output ready, done, rdata, err, ram_read, ram_write, ram_address, ram_data_in
  );
  modport ram (input ram_read, ram_write, ram_address, ram_data_in, output ram_data_out);
endinterface

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: loadable down-counter with zero flag, asynchronous active-high Clear.
// Ports: Clock, Clear, load_i (load LOAD), dec_i (decrement, saturating at 0), zero_o.
module mem_wait_counter
  import mem_ctrl_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int LOAD  = 0
) (
  input  logic Clock,
  input  logic Clear,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  assign zero_o = cnt_q == '0;
  assign cnt_d  = load_i ? WIDTH'(LOAD) : (dec_i && !zero_o) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one RAM read or write per request (IDLE -> ACCESS -> DONE).
// Ports: Clock, Clear (async active-high reset), bus (mem_access_ctrl_if.slave):
//   req/we/addr/wdata in, ready/done/rdata/err out, RAM strobes/address/data out, ram_data_out in.
// Build option: define MEM_ACCESS_CTRL_BOUNDS_CHECK_EN to flag requests whose upper address
//   bits are nonzero (done+err without touching RAM); otherwise they alias and err stays 0.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int CPU_ADDR_WIDTH = DEF_CPU_ADDR_WIDTH,
  parameter int WAIT_CYCLES    = 1
) (
  input  logic           Clock,
  input  logic           Clear,
  mem_access_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ACCESS = ACCESS;
  localparam logic [1:0] S_DONE   = DONE;
  localparam int CW = cnt_width(WAIT_CYCLES);
  logic [1:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d, rdata_q, rdata_d;
  logic                     we_q, we_d, err_q, err_d;
  logic                     accept, in_access, last, oob;
  assign accept    = (state_q == S_IDLE) && bus.req;
  assign in_access = state_q == S_ACCESS;
`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
  assign oob = |(bus.addr >> ADDRESS_WIDTH);
`else
  assign oob = 1'b0;
`endif
  mem_wait_counter #(.WIDTH(CW), .LOAD(WAIT_CYCLES)) u_wait (
    .Clock  (Clock),
    .Clear  (Clear),
    .load_i (accept),
    .dec_i  (in_access),
    .zero_o (last)
  );
  assign state_d = accept ? (oob ? S_DONE : S_ACCESS)
                 : (in_access && last) ? S_DONE
                 : (state_q == S_DONE) ? S_IDLE : state_q;
  assign addr_d  = accept ? bus.addr[ADDRESS_WIDTH-1:0] : addr_q;
  assign wdata_d = accept ? bus.wdata : wdata_q;
  assign we_d    = accept ? bus.we : we_q;
  assign err_d   = accept ? oob : err_q;
  // Read data is taken on the edge that leaves ACCESS, while the address is still stable.
  assign rdata_d = (in_access && last && !we_q) ? bus.ram_data_out : rdata_q;
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.ready       = state_q == S_IDLE;
  assign bus.done        = state_q == S_DONE;
  assign bus.err         = (state_q == S_DONE) && err_q;
  assign bus.rdata       = rdata_q;
  assign bus.ram_read    = in_access && !we_q;
  // Write strobe only in the last ACCESS cycle so the RAM sees exactly one falling edge.
  assign bus.ram_write   = in_access && we_q && last;
  assign bus.ram_address = addr_q;
  assign bus.ram_data_in = wdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl with WAIT_CYCLES=1 (u0) and 0 (u1).
module tb_mem_access_ctrl;
  logic Clock = 1'b0;
  logic Clear = 1'b1;
  logic load_mem = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];
  mem_access_ctrl_if b0 ();
  mem_access_ctrl_if b1 ();
  mem_access_ctrl #(.WAIT_CYCLES(1)) u0 (.Clock(Clock), .Clear(Clear), .bus(b0));
  mem_access_ctrl #(.WAIT_CYCLES(0)) u1 (.Clock(Clock), .Clear(Clear), .bus(b1));
  always #5 Clock = ~Clock;
  assign b0.ram_data_out = mem0[b0.ram_address];
  assign b1.ram_data_out = mem1[b1.ram_address];
  always @(negedge Clock) begin
    if (load_mem) begin
      for (int i = 0; i < 512; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
      mem0[0]     <= 32'h0BADF00D;
      mem0[1]     <= 32'h11111111;
      mem0[2]     <= 32'h22222222;
      mem0[3]     <= 32'h33333333;
      mem1[9'h1FF] <= 32'h12345678;
    end else begin
      if (b0.ram_write) mem0[b0.ram_address] <= b0.ram_data_in;
      if (b1.ram_write) mem1[b1.ram_address] <= b1.ram_data_in;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge Clock);
    #1;
  endtask
  initial begin
    int k;
    int last_c;
    b0.req = 0; b0.we = 0; b0.addr = '0; b0.wdata = '0;
    b1.req = 0; b1.we = 0; b1.addr = '0; b1.wdata = '0;
    #12;
    chk("rst_ready", 32'(b0.ready), 1);
    chk("rst_done", 32'(b0.done), 0);
    chk("rst_err", 32'(b0.err), 0);
    chk("rst_rdata", b0.rdata, 0);
    chk("rst_strobes", {30'd0, b0.ram_read, b0.ram_write}, 0);
    chk("rst_addr", 32'(b0.ram_address), 0);
    chk("rst_wdata", b0.ram_data_in, 0);
    load_mem = 0;
    @(posedge Clock);
    #1 Clear = 0;
    // write 0xDEADBEEF to 0x05
    b0.req = 1; b0.we = 1; b0.addr = 32'h5; b0.wdata = 32'hDEADBEEF;
    step;
    b0.req = 0; b0.addr = 32'h44; b0.wdata = 32'h0; b0.we = 0;
    chk("wr_busy", 32'(b0.ready), 0);
    chk("wr_early_strobe", {30'd0, b0.ram_read, b0.ram_write}, 0);
    chk("wr_addr", 32'(b0.ram_address), 32'h5);
    chk("wr_data", b0.ram_data_in, 32'hDEADBEEF);
    step;
    chk("wr_strobe", {30'd0, b0.ram_read, b0.ram_write}, 1);
    chk("wr_done_early", 32'(b0.done), 0);
    step;
    chk("wr_done", 32'(b0.done), 1);
    chk("wr_strobe_off", 32'(b0.ram_write), 0);
    chk("wr_mem", mem0[5], 32'hDEADBEEF);
    chk("wr_rdata_kept", b0.rdata, 0);
    step;
    chk("wr_idle", {30'd0, b0.ready, b0.done}, 2);
    // read back 0x05
    b0.req = 1; b0.we = 0; b0.addr = 32'h5;
    step;
    b0.req = 0;
    chk("rd_strobe1", {30'd0, b0.ram_read, b0.ram_write}, 2);
    chk("rd_addr", 32'(b0.ram_address), 32'h5);
    step;
    chk("rd_strobe2", 32'(b0.ram_read), 1);
    step;
    chk("rd_done", 32'(b0.done), 1);
    chk("rd_err", 32'(b0.err), 0);
    chk("rd_rdata", b0.rdata, 32'hDEADBEEF);
    chk("rd_strobe_off", 32'(b0.ram_read), 0);
    step;
    chk("rd_idle", 32'(b0.ready), 1);
    // WAIT_CYCLES=0 read of 0x1FF
    b1.req = 1; b1.we = 0; b1.addr = 32'h1FF;
    step;
    b1.req = 0;
    chk("w0_strobe", 32'(b1.ram_read), 1);
    chk("w0_addr", 32'(b1.ram_address), 32'h1FF);
    chk("w0_done_early", 32'(b1.done), 0);
    step;
    chk("w0_done", 32'(b1.done), 1);
    chk("w0_rdata", b1.rdata, 32'h12345678);
    chk("w0_strobe_off", 32'(b1.ram_read), 0);
    step;
    chk("w0_idle", {30'd0, b1.ready, b1.done}, 2);
    // busy ignore: second request to 0x10 during ACCESS/DONE
    b0.req = 1; b0.we = 0; b0.addr = 32'h2;
    step;
    b0.addr = 32'h10;
    chk("busy_addr0", 32'(b0.ram_address), 32'h2);
    step;
    chk("busy_addr1", 32'(b0.ram_address), 32'h2);
    chk("busy_nodone", 32'(b0.done), 0);
    step;
    chk("busy_done", 32'(b0.done), 1);
    chk("busy_addr2", 32'(b0.ram_address), 32'h2);
    chk("busy_rdata", b0.rdata, 32'h22222222);
    b0.req = 0;
    step;
    chk("busy_single", {30'd0, b0.ready, b0.done}, 2);
    // back-to-back reads of 0x01..0x03 with req held
    b0.req = 1; b0.we = 0; b0.addr = 32'h1;
    k = 0;
    last_c = 0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      step;
      if (b0.done) begin
        k++;
        chk("b2b_rdata", b0.rdata, {4{4'(k), 4'(k)}});
        if (k > 1) chk("b2b_spacing", 32'(c - last_c), 4);
        last_c = c;
        b0.addr = 32'(k + 1);
      end
    end
    b0.req = 0;
    chk("b2b_count", 32'(k), 3);
    step;
    // upper address bits set
    b0.req = 1; b0.we = 0; b0.addr = 32'h200;
    step;
    b0.req = 0;
`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
    chk("oob_done", 32'(b0.done), 1);
    chk("oob_err", 32'(b0.err), 1);
    chk("oob_nostrobe", {30'd0, b0.ram_read, b0.ram_write}, 0);
    step;
    chk("oob_idle", {30'd0, b0.ready, b0.done, b0.err}, 4);
    chk("oob_rdata", b0.rdata, 32'h33333333);
`else
    chk("alias_strobe", 32'(b0.ram_read), 1);
    chk("alias_addr", 32'(b0.ram_address), 0);
    step;
    step;
    chk("alias_done", 32'(b0.done), 1);
    chk("alias_err", 32'(b0.err), 0);
    chk("alias_rdata", b0.rdata, 32'h0BADF00D);
    step;
`endif
    // Clear during a write before its final ACCESS cycle
    b0.req = 1; b0.we = 1; b0.addr = 32'h7; b0.wdata = 32'hAAAA5555;
    step;
    b0.req = 0;
    chk("clr_pre_strobe", 32'(b0.ram_write), 0);
    chk("clr_pre_busy", 32'(b0.ready), 0);
    #2 Clear = 1;
    #1;
    chk("clr_ready", 32'(b0.ready), 1);
    chk("clr_done", 32'(b0.done), 0);
    chk("clr_strobe", {30'd0, b0.ram_read, b0.ram_write}, 0);
    chk("clr_addr", 32'(b0.ram_address), 0);
    chk("clr_wdata", b0.ram_data_in, 0);
    chk("clr_rdata", b0.rdata, 0);
    b0.req = 1; b0.we = 0; b0.addr = 32'h7;
    step;
    chk("clr_held", {30'd0, b0.ready, b0.done}, 2);
    Clear = 0;
    step;
    b0.req = 0;
    chk("clr_accept", 32'(b0.ram_read), 1);
    chk("clr_accept_addr", 32'(b0.ram_address), 32'h7);
    step;
    step;
    chk("clr_rd_done", 32'(b0.done), 1);
    chk("clr_rd_rdata", b0.rdata, 0);
    chk("clr_mem", mem0[7], 0);
    step;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
